// File: rtl/recip_divider_client.sv
// Integer divider front-end: fetches 1/b from an external reciprocal unit over a
// four-phase req/ack handshake, multiplies by a, then fixes the estimate stepwise.
module recip_divider_client #(
    parameter int unsigned N        = 8,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned MAX_CORR = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [3:0]       n_iter,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     q,
    output logic [N-1:0]     r,
    output logic             div_zero,
    output logic             err,
    output logic             rq_req,
    output logic [N-1:0]     rq_x,
    output logic [3:0]       rq_n_iter,
    input  logic [2*N-1:0]   rq_x_inv,
    input  logic             rq_ack
);
    localparam int unsigned RW = N + 2;
    localparam int unsigned PW = 3 * N;
    localparam int unsigned CW = 16;
    localparam int unsigned SW = (MAX_CORR < 1) ? 1 : $clog2(MAX_CORR + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ZERO, ST_REQ, ST_DROP, ST_MUL, ST_CORR, ST_OUT, ST_FAIL
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [2*N-1:0]  xinv_q, xinv_d;
    logic [RW-1:0]   qe_q, qe_d, re_q, re_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   step_q, step_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d, dz_q, dz_d;
    logic            rq_req_q, rq_req_d;
    logic [N-1:0]    rq_x_q, rq_x_d, q_q, q_d, r_q, r_d;
    logic [3:0]      rq_n_q, rq_n_d;

    logic [N-1:0]    qe_mul_c;
    logic            re_neg_c, re_ge_c, step_max_c, cnt_max_c;

    // Integer part of a * (x_inv / 2^2N); an N-bit slice never exceeds 2^N-1.
    assign qe_mul_c   = N'((PW'(a_q) * PW'(xinv_q)) >> (2 * N));
    assign re_neg_c   = re_q[RW-1];
    assign re_ge_c    = !re_q[RW-1] && (re_q >= RW'(b_q));
    assign step_max_c = (step_q == SW'(MAX_CORR));
    assign cnt_max_c  = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        xinv_d   = xinv_q;
        qe_d     = qe_q;
        re_d     = re_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        busy_d   = busy_q;
        dz_d     = dz_q;
        rq_x_d   = rq_x_q;
        rq_n_d   = rq_n_q;
        q_d      = q_q;
        r_d      = r_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        rq_req_d = 1'b0;
        case (state_q)
            // Start arriving while done/err is still visible is dropped.
            ST_IDLE: begin
                if (start && !done_q && !err_q) begin
                    a_d    = a;
                    b_d    = b;
                    busy_d = 1'b1;
                    dz_d   = 1'b0;
                    cnt_d  = '0;
                    if (b == '0) begin
                        state_d = ST_ZERO;
                    end else begin
                        rq_x_d   = b;
                        rq_n_d   = n_iter;
                        rq_req_d = 1'b1;
                        state_d  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (rq_ack) begin
                    xinv_d  = rq_x_inv;
                    cnt_d   = '0;
                    state_d = ST_DROP;
                end else if (cnt_max_c) begin
                    state_d = ST_FAIL;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    rq_req_d = 1'b1;
                end
            end
            ST_DROP: begin
                if (!rq_ack) begin
                    state_d = ST_MUL;
                end else if (cnt_max_c) begin
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_MUL: begin
                qe_d    = RW'(qe_mul_c);
                re_d    = RW'(a_q) - RW'(qe_mul_c) * RW'(b_q);
                step_d  = '0;
                state_d = ST_CORR;
            end
            ST_CORR: begin
                if (re_neg_c || re_ge_c) begin
                    if (step_max_c) begin
                        state_d = ST_FAIL;
                    end else begin
                        qe_d   = re_neg_c ? qe_q - RW'(1) : qe_q + RW'(1);
                        re_d   = re_neg_c ? re_q + RW'(b_q) : re_q - RW'(b_q);
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                q_d     = qe_q[N-1:0];
                r_d     = re_q[N-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ZERO: begin
                q_d     = '1;
                r_d     = a_q;
                dz_d    = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            xinv_q   <= '0;
            qe_q     <= '0;
            re_q     <= '0;
            cnt_q    <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dz_q     <= 1'b0;
            rq_req_q <= 1'b0;
            rq_x_q   <= '0;
            rq_n_q   <= '0;
            q_q      <= '0;
            r_q      <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            xinv_q   <= xinv_d;
            qe_q     <= qe_d;
            re_q     <= re_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dz_q     <= dz_d;
            rq_req_q <= rq_req_d;
            rq_x_q   <= rq_x_d;
            rq_n_q   <= rq_n_d;
            q_q      <= q_d;
            r_q      <= r_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign div_zero  = dz_q;
    assign rq_req    = rq_req_q;
    assign rq_x      = rq_x_q;
    assign rq_n_iter = rq_n_q;
    assign q         = q_q;
    assign r         = r_q;

endmodule

// File: tb/tb_recip_divider_client.sv
// Scoreboard bench for recip_divider_client with a behavioural reciprocal responder.
module tb_recip_divider_client;
    localparam int unsigned N   = 8;
    localparam int unsigned TMO = 10;

    logic           clock;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a, b;
    logic [3:0]     n_iter;
    logic           busy, done, div_zero, err, rq_req, rq_ack;
    logic [N-1:0]   q, r, rq_x;
    logic [3:0]     rq_n_iter;
    logic [2*N-1:0] rq_x_inv;

    recip_divider_client #(.N(N), .TIMEOUT(TMO), .MAX_CORR(3)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .a(a), .b(b), .n_iter(n_iter),
        .busy(busy), .done(done), .q(q), .r(r), .div_zero(div_zero), .err(err),
        .rq_req(rq_req), .rq_x(rq_x), .rq_n_iter(rq_n_iter),
        .rq_x_inv(rq_x_inv), .rq_ack(rq_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       is_err;
        logic       dz;
        logic [7:0] q;
        logic [7:0] r;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   prev_q = 0;
    int   prev_r = 0;
    int   cur_b = 0;
    int   cur_n = 0;

    int          resp_delay = 1;
    int          resp_hold = 0;
    bit          resp_never = 0;
    logic [15:0] resp_val = '0;
    int          wait_c = 0;
    int          hold_c = 0;

    task automatic check(input string nm, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int wrap10(input int v);
        int m;
        m = v & 1023;
        return (m >= 512) ? m - 1024 : m;
    endfunction

    // Reference: floor estimate from a*x_inv/2^16, then up to three +/-1 fixes on q.
    function automatic exp_t model(input int av, input int bv, input int xv, input bit never);
        exp_t   e;
        longint p;
        int     qe, re;
        e = '0;
        if (bv == 0) begin
            e.q = 8'hff; e.r = 8'(av); e.dz = 1'b1;
            return e;
        end
        e.is_err = 1'b1; e.q = 8'(prev_q); e.r = 8'(prev_r);
        if (never) return e;
        p  = longint'(av) * longint'(xv);
        qe = int'(p >> 16);
        if (qe > 255) qe = 255;
        re = wrap10(av - qe * bv);
        for (int s = 0; s <= 3; s++) begin
            if (re >= 0 && re < bv) begin
                e.is_err = 1'b0; e.q = 8'(qe & 255); e.r = 8'(re & 255);
                return e;
            end
            if (s == 3) return e;
            if (re < 0) begin qe = qe - 1; re = wrap10(re + bv); end
            else        begin qe = qe + 1; re = wrap10(re - bv); end
        end
        return e;
    endfunction

    // Responder: ack after resp_delay cycles of req, holds resp_hold cycles past req drop.
    initial begin
        rq_ack = 1'b0; rq_x_inv = '0;
        forever begin
            @(posedge clock); #1;
            if (!rst_n) begin
                rq_ack = 1'b0; wait_c = 0;
            end else if (rq_ack) begin
                if (!rq_req) begin
                    if (hold_c == 0) rq_ack = 1'b0;
                    else hold_c--;
                end
            end else if (rq_req && !resp_never) begin
                wait_c++;
                if (wait_c >= resp_delay) begin
                    rq_ack = 1'b1; rq_x_inv = resp_val; hold_c = resp_hold; wait_c = 0;
                end
            end else begin
                wait_c = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every done/err pulse.
    always @(negedge clock) begin
        exp_t e;
        if (rst_n) begin
            if (rq_req) begin
                check("rq_x_stable", rq_x, cur_b);
                check("rq_n_iter_stable", rq_n_iter, cur_n);
            end
            if (done || err) begin
                check("done_err_exclusive", done && err, 0);
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_response: done=%0b err=%0b with empty scoreboard", done, err);
                end else begin
                    e = sb.pop_front();
                    check("resp_kind_err", err, e.is_err);
                    check("q", q, e.q);
                    check("r", r, e.r);
                    check("div_zero", div_zero, e.dz);
                    check("busy_low_at_resp", busy, 0);
                    check("rq_req_low_at_resp", rq_req, 0);
                    prev_q = e.q; prev_r = e.r;
                end
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || done || err) && k < 300) begin
            @(negedge clock); k++;
        end
        if (k >= 300) begin
            tests++; fails++;
            $display("FAIL wait_idle: busy=%0b still set after %0d cycles", busy, k);
        end
    endtask

    task automatic do_div(input int av, input int bv, input int xv, input int dly, input int hold,
                          input bit never, input bit spurious, output int lat, output int req_cyc);
        wait_idle();
        resp_val = 16'(xv); resp_delay = dly; resp_hold = hold; resp_never = never;
        sb.push_back(model(av, bv, xv, never));
        a = 8'(av); b = 8'(bv); n_iter = 4'($urandom_range(0, 15));
        cur_b = bv; cur_n = int'(n_iter);
        start = 1'b1;
        lat = 0; req_cyc = 0;
        while (1) begin
            @(negedge clock);
            lat++;
            start = 1'b0;
            if (rq_req) req_cyc++;
            if (done || err) break;
            if (lat >= 200) begin
                tests++; fails++;
                $display("FAIL resp_timeout: no done/err after %0d cycles (a=%0d b=%0d)", lat, av, bv);
                break;
            end
            if (spurious && lat == 3) begin
                start = 1'b1; a = ~a; b = b ^ 8'h5a;
            end
        end
    endtask

    int lat1, lat2, lat, rc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; n_iter = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_rq_req", rq_req, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_rq_x", rq_x, 0);
        rst_n = 1'b1;
        @(negedge clock);

        do_div(200, 7, 9362, 3, 0, 0, 0, lat1, rc);
        check("t1_q", q, 28);
        check("t1_r", r, 4);
        // Start presented while done is high must be ignored.
        start = 1'b1; a = 8'd50; b = 8'd5;
        @(negedge clock);
        start = 1'b0;
        check("start_in_done_cycle_ignored", busy, 0);

        do_div(200, 7, 9000, 3, 0, 0, 0, lat2, rc);
        check("t2_q", q, 28);
        check("t2_r", r, 4);
        check("t2_latency_plus_one", lat2, lat1 + 1);

        do_div(255, 1, 65535, 1, 1, 0, 0, lat, rc);
        check("t3_q", q, 255);
        check("t3_r", r, 0);

        do_div(9, 0, 0, 1, 0, 0, 0, lat, rc);
        check("t4_no_req", rc, 0);
        check("t4_latency_le2", lat <= 2, 1);
        check("t4_q", q, 255);
        check("t4_r", r, 9);
        check("t4_div_zero", div_zero, 1);

        do_div(77, 3, 21845, 1, 0, 1, 0, lat, rc);
        check("t5_req_cycles", rc, TMO);
        check("t5_err", err, 1);
        check("t5_q_held", q, 255);
        check("t5_r_held", r, 9);

        // Reset in the middle of a request.
        wait_idle();
        resp_never = 1'b1;
        a = 8'd50; b = 8'd5; n_iter = 4'd3; cur_b = 5; cur_n = 3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("t6_in_req", rq_req, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rq_req_async", rq_req, 0);
        check("t6_busy", busy, 0);
        check("t6_q", q, 0);
        check("t6_r", r, 0);
        check("t6_rq_x", rq_x, 0);
        prev_q = 0; prev_r = 0; resp_never = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        do_div(100, 10, 6554, 2, 0, 0, 0, lat, rc);
        check("t6_q_after", q, 10);
        check("t6_r_after", r, 0);

        for (int i = 0; i < 40; i++) begin
            int av, bv, xv, base;
            av = int'($urandom_range(0, 255));
            bv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            base = (bv <= 1) ? 65535 : 65536 / bv;
            xv = base + int'($urandom_range(0, 6)) - 3;
            if (xv < 0) xv = 0;
            if (xv > 65535) xv = 65535;
            do_div(av, bv, xv, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 0,
                   bit'($urandom_range(0, 1)), lat, rc);
        end

        wait_idle();
        repeat (3) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
